// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined processor: opcode nibbles,
// instruction-length decode and the fetch FSM encoding.
package cpu_pkg;

    localparam logic [3:0] OP_LDM = 4'hC;
    localparam logic [3:0] OP_LDD = 4'hD;
    localparam logic [3:0] OP_STD = 4'hE;

    typedef enum logic [1:0] {
        VEC    = 2'd0,
        FETCH  = 2'd1,
        FETCH2 = 2'd2
    } fetch_state_t;

    // Only the memory-addressing opcodes carry a second (immediate/address) byte.
    function automatic logic is_two_byte(input logic [3:0] nib);
        return (nib == OP_LDM) || (nib == OP_LDD) || (nib == OP_STD);
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: loads the PC from the reset vector, assembles
// 1/2-byte instructions from same-cycle memory and registers the IF/ID bundle.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VEC_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  ifid_valid,
    output logic [DATA_WIDTH-1:0] ifid_instr,
    output logic [DATA_WIDTH-1:0] ifid_imm,
    output logic [ADDR_WIDTH-1:0] ifid_pc_next
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] op_hold;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic                  op_two_byte;

    assign pc_inc      = pc + 1'b1;
    assign op_two_byte = is_two_byte(i_data[DATA_WIDTH-1 -: 4]);

    always_comb begin
        i_addr = RESET_VEC_ADDR;
        case (state)
            FETCH, FETCH2: i_addr = pc;
            default:       i_addr = RESET_VEC_ADDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= VEC;
            pc           <= '0;
            op_hold      <= '0;
            ifid_valid   <= 1'b0;
            ifid_instr   <= '0;
            ifid_imm     <= '0;
            ifid_pc_next <= '0;
        end else begin
            case (state)
                VEC: begin
                    // Vector fetch ignores stall/redirect: the PC is not yet meaningful.
                    pc         <= ADDR_WIDTH'(i_data);
                    ifid_valid <= 1'b0;
                    state      <= FETCH;
                end
                FETCH: begin
                    if (redirect) begin
                        pc         <= redirect_pc;
                        ifid_valid <= 1'b0;
                    end else if (!stall) begin
                        if (op_two_byte) begin
                            op_hold    <= i_data;
                            pc         <= pc_inc;
                            ifid_valid <= 1'b0;
                            state      <= FETCH2;
                        end else begin
                            ifid_instr   <= i_data;
                            ifid_imm     <= '0;
                            ifid_pc_next <= pc_inc;
                            ifid_valid   <= 1'b1;
                            pc           <= pc_inc;
                        end
                    end
                end
                FETCH2: begin
                    if (redirect) begin
                        op_hold    <= '0;
                        pc         <= redirect_pc;
                        ifid_valid <= 1'b0;
                        state      <= FETCH;
                    end else if (!stall) begin
                        ifid_instr   <= op_hold;
                        ifid_imm     <= i_data;
                        ifid_pc_next <= pc_inc;
                        ifid_valid   <= 1'b1;
                        pc           <= pc_inc;
                        state        <= FETCH;
                    end
                end
                default: begin
                    state        <= VEC;
                    pc           <= '0;
                    op_hold      <= '0;
                    ifid_valid   <= 1'b0;
                    ifid_instr   <= '0;
                    ifid_imm     <= '0;
                    ifid_pc_next <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle-vector table, async-reset sequence and a
// scoreboard-checked random instruction stream with random stalls.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic [7:0] i_addr;
    logic [7:0] i_data;
    logic       ifid_valid;
    logic [7:0] ifid_instr;
    logic [7:0] ifid_imm;
    logic [7:0] ifid_pc_next;

    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       stall;
        logic       redir;
        logic [7:0] rpc;
        logic [7:0] iaddr;
        logic       valid;
        logic [7:0] instr;
        logic [7:0] imm;
        logic [7:0] pcn;
    } vec_t;

    typedef struct {
        logic [7:0] instr;
        logic [7:0] imm;
        logic [7:0] pcn;
    } exp_t;

    vec_t tbl [19];
    exp_t sb [$];

    always #5 clk = ~clk;

    assign i_data = mem[i_addr];

    instr_fetch #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .RESET_VEC_ADDR(8'd0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .i_addr(i_addr),
        .i_data(i_data),
        .ifid_valid(ifid_valid),
        .ifid_instr(ifid_instr),
        .ifid_imm(ifid_imm),
        .ifid_pc_next(ifid_pc_next)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bundle(input string tag, input logic v, input logic [7:0] ins,
                              input logic [7:0] im, input logic [7:0] pn);
        chk({tag, ".valid"}, {7'd0, ifid_valid}, {7'd0, v});
        chk({tag, ".instr"}, ifid_instr, ins);
        chk({tag, ".imm"}, ifid_imm, im);
        chk({tag, ".pc_next"}, ifid_pc_next, pn);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic two_byte_op(input logic [7:0] op);
        return (op[7:4] == 4'hC) || (op[7:4] == 4'hD) || (op[7:4] == 4'hE);
    endfunction

    initial begin
        logic [7:0] mpc;
        int         issued;
        exp_t       e;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h20; mem[8'h01] = 8'hC4; mem[8'h02] = 8'h99;
        mem[8'h20] = 8'h01; mem[8'h21] = 8'hC1; mem[8'h22] = 8'h5A;
        mem[8'h23] = 8'h02; mem[8'h24] = 8'hD3; mem[8'h25] = 8'h77;
        mem[8'h26] = 8'h05; mem[8'h27] = 8'hC1; mem[8'h28] = 8'h33;
        mem[8'h40] = 8'h06; mem[8'h41] = 8'h07; mem[8'hFF] = 8'h03;

        //          stall redir rpc    iaddr  valid instr  imm    pc_next
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00}; // VEC
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 8'h20, 1'b1, 8'h01, 8'h00, 8'h21};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 8'h21, 1'b0, 8'h01, 8'h00, 8'h21}; // C1 bubble
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 8'h22, 1'b1, 8'hC1, 8'h5A, 8'h23};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 8'h23, 1'b1, 8'h02, 8'h00, 8'h24};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 8'h24, 1'b0, 8'h02, 8'h00, 8'h24}; // D3 bubble
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 8'h25, 1'b0, 8'h02, 8'h00, 8'h24}; // stall in FETCH2
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 8'h25, 1'b0, 8'h02, 8'h00, 8'h24};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 8'h25, 1'b0, 8'h02, 8'h00, 8'h24};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 8'h25, 1'b1, 8'hD3, 8'h77, 8'h26};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 8'h26, 1'b1, 8'hD3, 8'h77, 8'h26}; // stall holds valid
        tbl[11] = '{1'b0, 1'b0, 8'h00, 8'h26, 1'b1, 8'h05, 8'h00, 8'h27};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 8'h27, 1'b0, 8'h05, 8'h00, 8'h27}; // C1 bubble
        tbl[13] = '{1'b1, 1'b1, 8'h40, 8'h28, 1'b0, 8'h05, 8'h00, 8'h27}; // redirect+stall
        tbl[14] = '{1'b0, 1'b0, 8'h00, 8'h40, 1'b1, 8'h06, 8'h00, 8'h41};
        tbl[15] = '{1'b0, 1'b1, 8'hFF, 8'h41, 1'b0, 8'h06, 8'h00, 8'h41}; // redirect in FETCH
        tbl[16] = '{1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h03, 8'h00, 8'h00}; // wrap
        tbl[17] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h20, 8'h00, 8'h01};
        tbl[18] = '{1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h20, 8'h00, 8'h01}; // C4 bubble

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        tick();
        tick();
        chk("reset.i_addr", i_addr, 8'h00);
        chk_bundle("reset", 1'b0, 8'h00, 8'h00, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            stall       = tbl[i].stall;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            #1;
            chk($sformatf("row%0d.i_addr", i), i_addr, tbl[i].iaddr);
            tick();
            chk_bundle($sformatf("row%0d", i), tbl[i].valid, tbl[i].instr, tbl[i].imm, tbl[i].pcn);
        end
        stall = 1'b0; redirect = 1'b0;

        // Async reset while in FETCH2 with C4 held: outputs clear before any edge.
        #2 rst = 1'b1;
        #1;
        chk("arst.i_addr", i_addr, 8'h00);
        chk_bundle("arst", 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        rst = 1'b0;
        chk("arst.vec_i_addr", i_addr, 8'h00);
        tick();
        chk_bundle("arst.vec", 1'b0, 8'h00, 8'h00, 8'h00);
        chk("arst.fetch_i_addr", i_addr, 8'h20);
        tick();
        chk_bundle("arst.first", 1'b1, 8'h01, 8'h00, 8'h21);

        // Random program at 0x60 with random stalls, checked against a memory walk.
        for (int a = 8'h60; a < 8'hB0; a++) mem[a] = 8'($urandom);
        redirect = 1'b1; redirect_pc = 8'h60;
        tick();
        redirect = 1'b0;
        chk("rand.start_i_addr", i_addr, 8'h60);
        mpc = 8'h60;
        issued = 0;
        for (int k = 0; k < 60; k++) begin
            stall = ($urandom_range(0, 3) == 0);
            if (!stall && sb.size() < 4) begin
                e.instr = mem[mpc];
                if (two_byte_op(mem[mpc])) begin
                    e.imm = mem[8'(mpc + 8'd1)];
                    mpc   = mpc + 8'd2;
                end else begin
                    e.imm = 8'h00;
                    mpc   = mpc + 8'd1;
                end
                e.pcn = mpc;
                sb.push_back(e);
            end
            tick();
            if (!stall && ifid_valid) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rand.extra: got instr %h with nothing expected", ifid_instr);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("rand%0d.instr", issued), ifid_instr, e.instr);
                    chk($sformatf("rand%0d.imm", issued), ifid_imm, e.imm);
                    chk($sformatf("rand%0d.pc_next", issued), ifid_pc_next, e.pcn);
                    issued++;
                end
            end
        end
        stall = 1'b0;
        total++;
        if (issued < 10) begin
            bad++;
            $display("FAIL rand.count: got %0d issued, expected at least 10", issued);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage of the 8-bit pipelined processor. It drives the instruction-port address of the unified memory and consumes the returned instruction byte, which is combinational and same-cycle. It loads the PC from the reset vector and assembles 1- or 2-byte instructions. It handles stall and branch redirect, and presents a registered IF/ID bundle to decode.

Parameters:
ADDR_WIDTH, 8, instruction address / PC width
DATA_WIDTH, 8, memory word width (instruction byte)
RESET_VEC_ADDR, 8'd0, memory address holding the initial PC

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  hazard unit: freeze PC, FSM and IF/ID
redirect  input  1  branch/jump taken: load PC from redirect_pc, squash in-flight fetch
redirect_pc  input  ADDR_WIDTH  redirect target
i_addr  output  ADDR_WIDTH  instruction address to memory
i_data  input  DATA_WIDTH  instruction byte from memory (same-cycle)
ifid_valid  output  1  IF/ID holds a real instruction
ifid_instr  output  DATA_WIDTH  opcode byte
ifid_imm  output  DATA_WIDTH  second byte for 2-byte instructions, else 0
ifid_pc_next  output  ADDR_WIDTH  address following the instruction

Behaviour:
- Clocking and reset:
  - Single clock domain; all state on posedge clk; rst asynchronous, active-high.
  - Reset values: state=VEC, pc=0, op_hold=0, ifid_valid=0, ifid_instr=0, ifid_imm=0, ifid_pc_next=0.
- i_addr is combinational from state:
  - VEC -> RESET_VEC_ADDR.
  - FETCH and FETCH2 -> pc.
- Two-byte opcodes: i_data[7:4] in {4'hC LDM, 4'hD LDD, 4'hE STD}. All other opcodes are 1 byte.
- Priority each cycle: rst > (state VEC) > redirect > stall > normal advance.
- VEC:
  - pc <= i_data; state <= FETCH; ifid_valid <= 0.
  - stall and redirect are ignored. Exactly one cycle after reset release.
- FETCH, redirect:
  - pc <= redirect_pc; ifid_valid <= 0; state stays FETCH.
- FETCH, stall:
  - All registers hold, including the IF/ID bundle and ifid_valid.
- FETCH, 1-byte opcode:
  - ifid_instr <= i_data; ifid_imm <= 0; ifid_pc_next <= pc+1; ifid_valid <= 1; pc <= pc+1.
- FETCH, 2-byte opcode:
  - op_hold <= i_data; pc <= pc+1; ifid_valid <= 0 (bubble); state <= FETCH2.
- FETCH2, redirect:
  - Discard op_hold; pc <= redirect_pc; ifid_valid <= 0; state <= FETCH.
- FETCH2, stall:
  - Hold everything; remain in FETCH2.
- FETCH2, normal:
  - ifid_instr <= op_hold; ifid_imm <= i_data; ifid_pc_next <= pc+1; ifid_valid <= 1; pc <= pc+1; state <= FETCH.
- Throughput and latency:
  - 1-byte instruction: one per cycle; appears in IF/ID the cycle after its address is driven.
  - 2-byte instruction: two cycles, one bubble.
- PC arithmetic: modulo 2^ADDR_WIDTH; 8'hFF+1 wraps to 8'h00, including between opcode and immediate bytes. No fault is raised.
- Redirect and stall together: redirect wins; the squash takes effect even while stalled.
- Reset mid-operation (any state): immediate return to VEC with all outputs at reset values; op_hold is discarded.
- Unused encoding state: next state VEC, outputs cleared.

Decomposition:
- Shared package cpu_pkg:
  - opcode nibble constants (OP_LDM=4'hC, OP_LDD=4'hD, OP_STD=4'hE);
  - is_two_byte function on the upper nibble;
  - fetch state encoding VEC / FETCH / FETCH2 (2 bits).
- No sub-module: PC register, FSM and IF/ID register all live in instr_fetch.

Test Plan:
- Reset vector: M[0]=8'h20, M[0x20]=8'h01, rst pulse -> i_addr=0 in VEC, then i_addr=8'h20; next cycle ifid_valid=1, ifid_instr=8'h01, ifid_pc_next=8'h21.
- 2-byte assembly: M[0x20]=8'hC1, M[0x21]=8'h5A, M[0x22]=8'h02 -> one cycle ifid_valid=0; then {instr=C1, imm=5A, pc_next=22, valid=1}; next cycle {instr=02, imm=00, pc_next=23}.
- Stall: stall high 3 cycles mid-stream, including in FETCH2 -> i_addr, pc and IF/ID constant; resumes with no lost or duplicated byte.
- Redirect in FETCH2: after opcode C1 fetched, redirect=1 with redirect_pc=8'h40 and stall=1 -> ifid_valid=0, next i_addr=8'h40, C1 never issued.
- Wrap: PC=8'hFF holding 1-byte opcode 8'h03, M[0]=8'h04 -> ifid_pc_next=8'h00, next fetch from i_addr=0.
- Async reset mid-FETCH2: assert rst between clock edges -> outputs cleared immediately, re-enters VEC, no instruction issued from stale op_hold.
